idelay_tap_calibrator: RTL and testbench
========================================

// Module: idelay_tap_calibrator
// PURPOSE
//  Upstream control stage for the IDELAYE3 thermometer delay line. Drives its CE/INC/EN_VTC/RST pins
//  to sweep every tap from 0 to NUM_TAPS, and grades each tap from sampled-data compare results.
//  Selects the longest contiguous passing window and parks the delay line on that window's centre.
//  Sits between the link training logic (START, SAMPLE_OK) and one IDELAYE3 instance.
// PARAMETERS
//  NUM_TAPS         6   cascade length of the driven delay line; legal taps are 0..NUM_TAPS
//  SETTLE_CYCLES    4   idle cycles after each tap change before sampling starts (>=1)
//  SAMPLES_PER_TAP  16  SAMPLE_VALID beats graded per tap (>=1)
// PORTS
//  CLK           in   1      clock (same domain as delay line CLK)
//  RST           in   1      reset, asynchronous, active-high
//  START         in   1      pulse: begin calibration (honoured in IDLE/DONE/FAIL only)
//  SAMPLE_VALID  in   1      SAMPLE_OK is valid this cycle
//  SAMPLE_OK     in   1      1 = sampled word matched training pattern
//  DLY_RST       out  1      to IDELAYE3.RST
//  DLY_CE        out  1      to IDELAYE3.CE
//  DLY_INC       out  1      to IDELAYE3.INC
//  DLY_EN_VTC    out  1      to IDELAYE3.EN_VTC
//  BUSY          out  1      calibration in progress
//  DONE          out  1      level: calibrated, delay parked at TAP_OUT
//  FAIL          out  1      level: no passing tap found
//  TAP_OUT       out  TAP_W  current tap of the delay line (tracked shadow)
//  WIN_LEN       out  TAP_W+1 length of the chosen window (0 on FAIL)
//  PASS_MAP      out  NUM_TAPS+1  per-tap pass bitmap, bit i = tap i (only with IDELAY_CAL_MAP_EN)
// BEHAVIOUR
//  - TAP_W = $clog2(NUM_TAPS+1). All outputs are registered.
//  - Reset values: DLY_RST=1, DLY_EN_VTC=1, DLY_CE=0, DLY_INC=0, BUSY=DONE=FAIL=0,
//    TAP_OUT=0, WIN_LEN=0. DLY_RST drops to 0 on the first CLK after RST deasserts.
//  - FSM states: IDLE, DRST, SETTLE, SAMPLE, EVAL, STEP, RETURN, GAP, DONE, FAIL.
//  - IDLE/DONE/FAIL + START -> DRST.
//  - DRST: DLY_RST=1 for 1 cycle; TAP_OUT=0; tracker cleared; DLY_EN_VTC=0 from here until DONE/FAIL.
//  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
//  - SAMPLE: count SAMPLES_PER_TAP SAMPLE_VALID beats. The tap passes iff every graded beat has
//    SAMPLE_OK=1. Beats outside SAMPLE are ignored. No timeout: a stalled SAMPLE_VALID holds SAMPLE.
//  - EVAL (1 cycle): update the window tracker.
//    If TAP_OUT==NUM_TAPS, go to RETURN; otherwise go to STEP.
//  - STEP (1 cycle): DLY_CE=1, DLY_INC=1, TAP_OUT+=1, then go to SETTLE.
//  - Window tracker: keeps the longest run of consecutive passing taps. On a tie the earlier
//    window wins. centre = best_start + (best_len-1)>>1 (floor).
//  - RETURN:
//    - best_len==0: go to FAIL. FAIL pulses DLY_RST once, sets TAP_OUT=0 and WIN_LEN=0.
//    - TAP_OUT>centre: drive one cycle of DLY_CE=1, DLY_INC=0 and TAP_OUT-=1, then one GAP cycle
//      with CE=0. Repeat until TAP_OUT==centre, then go to DONE.
//  - DONE/FAIL: DLY_EN_VTC=1, BUSY=0, level held until the next START.
//  - BUSY=1 in every state except IDLE/DONE/FAIL. DONE and FAIL are never both 1.
//  - DLY_CE is never asserted while DLY_EN_VTC=1 or DLY_RST=1.
//  - TAP_OUT never exceeds NUM_TAPS and never wraps below 0.
//  - START while BUSY is ignored.
//  - RST mid-sweep returns to the reset values immediately. Because DLY_RST=1, the delay line is
//    reset as well, so the shadow tap stays consistent.
// CONFIGURATION
//  IDELAY_CAL_MAP_EN defined:
//    - PASS_MAP port and its register exist.
//    - PASS_MAP is cleared in DRST; bit TAP_OUT is written in EVAL; it holds through DONE/FAIL.
//  IDELAY_CAL_MAP_EN undefined: no PASS_MAP port or register; all other behaviour is identical.
// STRUCTURE
//  - Package idelay_cal_pkg holds:
//    - cal_state_t enum (the states above);
//    - function tap_w(n) = $clog2(n+1);
//    - the default parameter constants.
//  - Sub-module cal_window_tracker holds:
//    - inputs: clr, upd, pass;
//    - run/best start and length registers;
//    - outputs: centre, best_len.
//  - Top level holds the FSM, counters and output registers.
// TESTING (NUM_TAPS=6, SETTLE_CYCLES=4, SAMPLES_PER_TAP=16, bench drives SAMPLE_VALID every cycle)
//  1. Taps 2..5 pass -> DONE=1, TAP_OUT=3, WIN_LEN=4; 3 decrement CE pulses after tap 6;
//     the bench delay model select=0x07.
//  2. All taps fail -> FAIL=1, DONE=0, TAP_OUT=0, WIN_LEN=0, one DLY_RST pulse, DLY_EN_VTC=1.
//  3. Taps {0,1} and {3,4,5} pass -> TAP_OUT=4, WIN_LEN=3; PASS_MAP=7'b0111011 when the macro is defined.
//  4. All taps pass -> TAP_OUT=3, WIN_LEN=7.
//     Tie {1} vs {4} -> TAP_OUT=1, WIN_LEN=1.
//  5. A single SAMPLE_OK=0 on beat 9 at tap 4, taps 1..6 otherwise pass -> tap 4 fails;
//     result TAP_OUT=2, WIN_LEN=3.
//  6. RST asserted during STEP at tap 3 -> all outputs take reset values at once.
//     A new START recalibrates correctly. START pulses while BUSY have no effect.
//  All runs: assert DLY_CE never coincides with DLY_EN_VTC=1, and TAP_OUT matches the popcount of the model select.

Source files
------------

// File: rtl/idelay_cal_pkg.sv
// Shared types and constants for the IDELAYE3 tap calibrator.
//   cal_state_t : calibration FSM states
//   tap_w(n)    : bits needed to hold a tap index 0..n
//   DEF_*       : default parameter values
package idelay_cal_pkg;

    localparam int unsigned DEF_NUM_TAPS        = 6;
    localparam int unsigned DEF_SETTLE_CYCLES   = 4;
    localparam int unsigned DEF_SAMPLES_PER_TAP = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DRST,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_RETURN,
        ST_GAP,
        ST_DONE,
        ST_FAIL
    } cal_state_t;

    function automatic int unsigned tap_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cal_window_tracker.sv
// Tracks the longest run of consecutive passing taps (earlier run wins ties).
// Ports:
//   CLK, RST        clock, async active-high reset
//   clr             clear all run/best state
//   upd             grade tap 'tap' with result 'pass'
//   centre          floor centre of the best window (registered)
//   best_len        length of the best window, 0 if none (registered)
module cal_window_tracker
    import idelay_cal_pkg::*;
#(
    parameter  int unsigned NUM_TAPS = DEF_NUM_TAPS,
    localparam int unsigned TAP_W    = tap_w(NUM_TAPS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             upd,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] centre,
    output logic [TAP_W:0]   best_len
);

    logic [TAP_W-1:0] run_start_q, run_start_d;
    logic [TAP_W:0]   run_len_q,   run_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [TAP_W:0]   best_len_q,   best_len_d;
    logic [TAP_W-1:0] centre_q,     centre_d;

    // Extend or break the current run; promote it only when strictly longer.
    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        centre_d     = centre_q;
        if (clr) begin
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
            centre_d     = '0;
        end else if (upd) begin
            if (pass) begin
                run_len_d   = run_len_q + (TAP_W+1)'(1);
                run_start_d = (run_len_q == '0) ? tap : run_start_q;
                if (run_len_d > best_len_q) begin
                    best_start_d = run_start_d;
                    best_len_d   = run_len_d;
                    centre_d     = run_start_d + TAP_W'((run_len_d - (TAP_W+1)'(1)) >> 1);
                end
            end else begin
                run_len_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            centre_q     <= '0;
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            centre_q     <= centre_d;
        end
    end

    assign centre   = centre_q;
    assign best_len = best_len_q;

endmodule

// File: rtl/idelay_tap_calibrator.sv
// Sweeps an IDELAYE3 across taps 0..NUM_TAPS, grades each tap from SAMPLE_OK beats,
// then steps back to the centre of the longest passing window.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   START                    begin calibration (ignored while BUSY)
//   SAMPLE_VALID, SAMPLE_OK  compare result stream from link training
//   DLY_RST/CE/INC/EN_VTC    IDELAYE3 control pins
//   BUSY, DONE, FAIL         status levels
//   TAP_OUT, WIN_LEN         shadow tap and chosen window length
//   PASS_MAP                 per-tap pass bitmap (only when IDELAY_CAL_MAP_EN is defined)
module idelay_tap_calibrator
    import idelay_cal_pkg::*;
#(
    parameter  int unsigned NUM_TAPS        = DEF_NUM_TAPS,
    parameter  int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter  int unsigned SAMPLES_PER_TAP = DEF_SAMPLES_PER_TAP,
    localparam int unsigned TAP_W           = tap_w(NUM_TAPS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SAMPLE_VALID,
    input  logic             SAMPLE_OK,
    output logic             DLY_RST,
    output logic             DLY_CE,
    output logic             DLY_INC,
    output logic             DLY_EN_VTC,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] TAP_OUT,
    output logic [TAP_W:0]   WIN_LEN
`ifdef IDELAY_CAL_MAP_EN
    ,
    output logic [NUM_TAPS:0] PASS_MAP
`endif
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLES_PER_TAP) ? SETTLE_CYCLES : SAMPLES_PER_TAP;
    localparam int unsigned CNT_W   = tap_w(CNT_MAX);

    cal_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             dly_rst_q, dly_rst_d;
    logic             dly_ce_q, dly_ce_d;
    logic             dly_inc_q, dly_inc_d;
    logic             dly_en_vtc_q, dly_en_vtc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W:0]   win_len_q, win_len_d;
    logic             trk_clr, trk_upd;
    logic [TAP_W-1:0] centre;
    logic [TAP_W:0]   best_len;
`ifdef IDELAY_CAL_MAP_EN
    logic [NUM_TAPS:0] pass_map_q, pass_map_d;
`endif

    cal_window_tracker #(.NUM_TAPS(NUM_TAPS)) u_tracker (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (trk_clr),
        .upd      (trk_upd),
        .pass     (ok_q),
        .tap      (tap_q),
        .centre   (centre),
        .best_len (best_len)
    );

    // Next-state and registered-output logic; outputs are set on entry to each state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ok_d         = ok_q;
        dly_rst_d    = 1'b0;
        dly_ce_d     = 1'b0;
        dly_inc_d    = 1'b0;
        dly_en_vtc_d = dly_en_vtc_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        tap_d        = tap_q;
        win_len_d    = win_len_q;
        trk_clr      = 1'b0;
        trk_upd      = 1'b0;
`ifdef IDELAY_CAL_MAP_EN
        pass_map_d   = pass_map_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (START) begin
                    state_d      = ST_DRST;
                    dly_rst_d    = 1'b1;
                    dly_en_vtc_d = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    fail_d       = 1'b0;
                    tap_d        = '0;
                    win_len_d    = '0;
                end
            end
            ST_DRST: begin
                trk_clr = 1'b1;
`ifdef IDELAY_CAL_MAP_EN
                pass_map_d = '0;
`endif
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    ok_d    = 1'b1;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (SAMPLE_VALID) begin
                    ok_d = ok_q & SAMPLE_OK;
                    if (cnt_q == CNT_W'(SAMPLES_PER_TAP - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EVAL: begin
                trk_upd = 1'b1;
`ifdef IDELAY_CAL_MAP_EN
                pass_map_d[tap_q] = ok_q;
`endif
                if (tap_q == TAP_W'(NUM_TAPS)) begin
                    state_d = ST_RETURN;
                end else begin
                    state_d   = ST_STEP;
                    dly_ce_d  = 1'b1;
                    dly_inc_d = 1'b1;
                    tap_d     = tap_q + TAP_W'(1);
                end
            end
            ST_STEP: state_d = ST_SETTLE;
            ST_RETURN: begin
                if (best_len == '0) begin
                    state_d      = ST_FAIL;
                    dly_rst_d    = 1'b1;
                    dly_en_vtc_d = 1'b1;
                    busy_d       = 1'b0;
                    fail_d       = 1'b1;
                    tap_d        = '0;
                    win_len_d    = '0;
                end else if (tap_q > centre) begin
                    state_d  = ST_GAP;
                    dly_ce_d = 1'b1;
                    tap_d    = tap_q - TAP_W'(1);
                end else begin
                    state_d      = ST_DONE;
                    dly_en_vtc_d = 1'b1;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    win_len_d    = best_len;
                end
            end
            ST_GAP:  state_d = ST_RETURN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ok_q         <= 1'b0;
            dly_rst_q    <= 1'b1;
            dly_ce_q     <= 1'b0;
            dly_inc_q    <= 1'b0;
            dly_en_vtc_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            tap_q        <= '0;
            win_len_q    <= '0;
`ifdef IDELAY_CAL_MAP_EN
            pass_map_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ok_q         <= ok_d;
            dly_rst_q    <= dly_rst_d;
            dly_ce_q     <= dly_ce_d;
            dly_inc_q    <= dly_inc_d;
            dly_en_vtc_q <= dly_en_vtc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            tap_q        <= tap_d;
            win_len_q    <= win_len_d;
`ifdef IDELAY_CAL_MAP_EN
            pass_map_q   <= pass_map_d;
`endif
        end
    end

    assign DLY_RST    = dly_rst_q;
    assign DLY_CE     = dly_ce_q;
    assign DLY_INC    = dly_inc_q;
    assign DLY_EN_VTC = dly_en_vtc_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign FAIL       = fail_q;
    assign TAP_OUT    = tap_q;
    assign WIN_LEN    = win_len_q;
`ifdef IDELAY_CAL_MAP_EN
    assign PASS_MAP   = pass_map_q;
`endif

endmodule

// File: tb/tb_idelay_tap_calibrator.sv
// Directed bench for idelay_tap_calibrator with a thermometer delay-line model.
// Build with IDELAY_CAL_MAP_EN defined to also cover PASS_MAP.
module tb_idelay_tap_calibrator;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       SAMPLE_VALID = 1'b1;
    logic       SAMPLE_OK = 1'b0;
    logic       DLY_RST, DLY_CE, DLY_INC, DLY_EN_VTC;
    logic       BUSY, DONE, FAIL;
    logic [2:0] TAP_OUT;
    logic [3:0] WIN_LEN;
`ifdef IDELAY_CAL_MAP_EN
    logic [6:0] PASS_MAP;
`endif

    idelay_tap_calibrator dut (
        .CLK          (CLK),
        .RST          (RST),
        .START        (START),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_OK    (SAMPLE_OK),
        .DLY_RST      (DLY_RST),
        .DLY_CE       (DLY_CE),
        .DLY_INC      (DLY_INC),
        .DLY_EN_VTC   (DLY_EN_VTC),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .FAIL         (FAIL),
        .TAP_OUT      (TAP_OUT),
        .WIN_LEN      (WIN_LEN)
`ifdef IDELAY_CAL_MAP_EN
        ,
        .PASS_MAP     (PASS_MAP)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Delay-line model: thermometer select, one bit per tap above 0.
    logic [5:0] sel = '0;
    logic [5:0] nsel;
    int         cyc = 0;
    int         dec_cnt = 0;
    int         idle_rst_cnt = 0;
    int         busy_rst_cnt = 0;
    int         viol_cnt = 0;
    logic [6:0] pass_vec = '0;
    bit         glitch_en = 1'b0;

    always @(posedge CLK) begin
        nsel = sel;
        if (DLY_RST) nsel = '0;
        else if (DLY_CE) nsel = DLY_INC ? {sel[4:0], 1'b1} : {1'b0, sel[5:1]};
        cyc <= (nsel != sel) ? 0 : cyc + 1;
        sel <= nsel;
        if (DLY_CE && !DLY_INC) dec_cnt <= dec_cnt + 1;
        if (DLY_RST && !BUSY && !RST) idle_rst_cnt <= idle_rst_cnt + 1;
        if (DLY_RST && BUSY) busy_rst_cnt <= busy_rst_cnt + 1;
        if ((DLY_CE && (DLY_EN_VTC || DLY_RST)) || (DONE && FAIL)) viol_cnt <= viol_cnt + 1;
    end

    // Training data: pass/fail per model tap; optional one-beat glitch at tap 4 (beat 9).
    always @(negedge CLK) begin
        int t;
        t = $countones(sel);
        SAMPLE_OK = pass_vec[t] && !(glitch_en && t == 4 && cyc == 12);
    end

    int dec0, idle0, busy0;

    task automatic run_cal(input logic [6:0] pv, input bit gl);
        pass_vec  = pv;
        glitch_en = gl;
        dec0  = dec_cnt;
        idle0 = idle_rst_cnt;
        busy0 = busy_rst_cnt;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        for (int i = 0; i < 3000; i++) begin
            if (DONE || FAIL) break;
            @(negedge CLK);
        end
        check("timeout", (DONE || FAIL) ? 0 : 1, 0);
        @(negedge CLK);
    endtask

    task automatic check_done(input string tag, input int tap, input int win);
        check({tag, "_done"}, DONE, 1);
        check({tag, "_fail"}, FAIL, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_tap"}, TAP_OUT, tap);
        check({tag, "_win"}, WIN_LEN, win);
        check({tag, "_model_tap"}, $countones(sel), tap);
        check({tag, "_vtc"}, DLY_EN_VTC, 1);
        check({tag, "_viol"}, viol_cnt, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_dly_rst", DLY_RST, 1);
        check("rst_vtc", DLY_EN_VTC, 1);
        check("rst_ce", DLY_CE, 0);
        check("rst_inc", DLY_INC, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_fail", FAIL, 0);
        check("rst_tap", TAP_OUT, 0);
        check("rst_win", WIN_LEN, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_release_dly_rst", DLY_RST, 0);

        // 1: taps 2..5 pass
        run_cal(7'b0111100, 1'b0);
        check_done("t1", 3, 4);
        check("t1_dec_pulses", dec_cnt - dec0, 3);
        check("t1_select", sel, 7);

        // 2: all taps fail
        run_cal(7'b0000000, 1'b0);
        check("t2_fail", FAIL, 1);
        check("t2_done", DONE, 0);
        check("t2_tap", TAP_OUT, 0);
        check("t2_win", WIN_LEN, 0);
        check("t2_vtc", DLY_EN_VTC, 1);
        check("t2_rst_pulses", idle_rst_cnt - idle0, 1);
        check("t2_model_tap", $countones(sel), 0);

        // 3: {0,1} and {3,4,5}
        run_cal(7'b0111011, 1'b0);
        check_done("t3", 4, 3);
`ifdef IDELAY_CAL_MAP_EN
        check("t3_pass_map", PASS_MAP, 7'b0111011);
`endif

        // 4: all pass, then tie {1} vs {4}
        run_cal(7'b1111111, 1'b0);
        check_done("t4a", 3, 7);
        run_cal(7'b0010010, 1'b0);
        check_done("t4b", 1, 1);

        // 5: taps 1..6 pass but tap 4 sees one bad beat
        run_cal(7'b1111110, 1'b1);
        check_done("t5", 2, 3);
`ifdef IDELAY_CAL_MAP_EN
        check("t5_pass_map", PASS_MAP, 7'b1101110);
`endif

        // 6: reset during STEP at tap 3
        pass_vec  = 7'b1111111;
        glitch_en = 1'b0;
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (DLY_CE && DLY_INC && TAP_OUT == 3'd3) break;
            @(negedge CLK);
        end
        check("t6_reach_step3", (DLY_CE && DLY_INC && TAP_OUT == 3'd3) ? 1 : 0, 1);
        RST = 1'b1;
        #1;
        check("t6_dly_rst", DLY_RST, 1);
        check("t6_vtc", DLY_EN_VTC, 1);
        check("t6_ce", DLY_CE, 0);
        check("t6_inc", DLY_INC, 0);
        check("t6_busy", BUSY, 0);
        check("t6_done", DONE, 0);
        check("t6_fail", FAIL, 0);
        check("t6_tap", TAP_OUT, 0);
        check("t6_win", WIN_LEN, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("t6_model_reset", sel, 0);

        // Recalibrate with extra START pulses while busy
        busy0 = busy_rst_cnt;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (DONE || FAIL) break;
            START = (i == 10 || i == 60 || i == 130);
            @(negedge CLK);
        end
        START = 1'b0;
        check("t6_timeout", (DONE || FAIL) ? 0 : 1, 0);
        @(negedge CLK);
        check_done("t6", 3, 7);
        check("t6_single_drst", busy_rst_cnt - busy0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
